// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch hazard handling and MEM-wait freeze
// sequencer for the 5-stage core. Optional statistics counters are built
// only when HAZARD_STATS_EN is defined; otherwise both counters read 0.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             bubble_o,
  output logic             ifid_flush_o,
  output logic             freeze_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEMWAIT, S_ERROR} state_t;

  // Last wait-counter value; reaching it without an ack means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       load_use;
  logic       advance;   // pipeline moves this cycle: hazards are evaluated
  logic       stall_ev;  // a load-use bubble is inserted this cycle

  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  // Next-state and same-cycle control outputs
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    bubble_o     = 1'b0;
    ifid_flush_o = 1'b0;
    freeze_o     = 1'b0;
    advance      = 1'b0;
    stall_ev     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bubble_o = 1'b1;
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          freeze_o = 1'b1;
          state_d  = S_MEMWAIT;
          wcnt_d   = 8'd0;
        end else begin
          advance = 1'b1;
        end
      end
      S_MEMWAIT: begin
        if (mem_ack_i) begin
          // Access completes: the pipeline advances normally this cycle.
          state_d = S_RUN;
          advance = 1'b1;
        end else begin
          freeze_o = 1'b1;
          wcnt_d   = wcnt_q + 8'd1;
          if (wcnt_d == WAIT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        bubble_o = 1'b1;
      end
    endcase
    if (advance) begin
      if (load_use) begin
        bubble_o = 1'b1;
        stall_ev = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = branch_taken_i;
      end
    end
  end

  // State, wait counter and sticky error register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, freeze_cnt_q;

  // Saturating hazard statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_ev && !(&stall_cnt_q))  stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (freeze_o && !(&freeze_cnt_q)) freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign freeze_cnt_o = freeze_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = stall_ev;
  assign stall_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed steps from the test plan followed by
// randomized cycles, all checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
  localparam int MT    = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, memrd, br, req, ack;
  logic [4:0] exrt, rs, rt;
  logic pc_w, ifid_w, bub, flush, frz, err;
  logic [CNT_W-1:0] scnt, fcnt;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .idex_memread_i(memrd),
    .idex_rt_i(exrt), .ifid_rs_i(rs), .ifid_rt_i(rt), .branch_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack), .pc_write_o(pc_w), .ifid_write_o(ifid_w),
    .bubble_o(bub), .ifid_flush_o(flush), .freeze_o(frz), .err_o(err),
    .stall_cnt_o(scnt), .freeze_cnt_o(fcnt));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: started/errored flags, whether an access is outstanding and how
  // many frozen cycles it has cost so far; counters kept as plain integers.
  bit m_run = 0, m_err = 0, m_wait = 0;
  int m_frozen = 0, m_stall = 0, m_fcnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit m, input int ert,
                     input int irs, input int irt, input bit b,
                     input bit q, input bit a);
    bit lu, fz, e_pc, e_if, e_bub, e_fl;
    rst = r; start = s; memrd = m; exrt = 5'(ert); rs = 5'(irs); rt = 5'(irt);
    br = b; req = q; ack = a;
    lu = m && ert != 0 && (ert == irs || ert == irt);
    fz = 0; e_pc = 0; e_if = 0; e_bub = 0; e_fl = 0;
    if (!m_run || m_err) e_bub = 1;
    else if ((m_wait && !a) || (!m_wait && q && !a)) fz = 1;
    else if (lu) e_bub = 1;
    else begin e_pc = 1; e_if = 1; e_fl = b; end
    @(negedge clk);
    chk("pc_write", int'(pc_w), int'(e_pc));
    chk("ifid_write", int'(ifid_w), int'(e_if));
    chk("bubble", int'(bub), int'(e_bub));
    chk("ifid_flush", int'(flush), int'(e_fl));
    chk("freeze", int'(frz), int'(fz));
    @(posedge clk);
    if (r) begin
      m_run = 0; m_err = 0; m_wait = 0; m_frozen = 0; m_stall = 0; m_fcnt = 0;
    end else begin
      if (m_run && !m_err && !fz && lu && m_stall < CMAX) m_stall++;
      if (fz && m_fcnt < CMAX) m_fcnt++;
      if (!m_run) m_run = s;
      else if (!m_err) begin
        if (fz) begin
          m_frozen = m_wait ? m_frozen + 1 : 1;
          m_wait = 1;
          if (m_frozen == MT) begin m_err = 1; m_wait = 0; end
        end else m_wait = 0;
      end
    end
    #1;
    chk("err", int'(err), int'(m_err));
    chk("stall_cnt", int'(scnt), STATS ? m_stall : 0);
    chk("freeze_cnt", int'(fcnt), STATS ? m_fcnt : 0);
  endtask

  initial begin
    rst = 1; start = 0; memrd = 0; exrt = 0; rs = 0; rt = 0;
    br = 0; req = 0; ack = 0;
    // reset, then start from IDLE
    cyc(1,0,0,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    // load-use on rs, then same with rt=0 (no stall), then on rt
    cyc(0,0,1,8,8,3,0,0,0);
    cyc(0,0,1,0,0,0,0,0,0);
    cyc(0,0,1,9,2,9,0,0,0);
    // load-use beats branch, branch taken next cycle flushes
    cyc(0,0,1,8,8,0,1,0,0);
    cyc(0,0,0,8,8,0,1,0,0);
    // 3 frozen cycles with concurrent load-use, then ack
    cyc(0,0,1,8,8,0,0,1,0);
    cyc(0,0,1,8,8,0,1,1,0);
    cyc(0,0,1,8,8,0,0,1,0);
    cyc(0,0,0,0,0,0,0,1,1);
    // zero-wait access
    cyc(0,0,0,0,0,0,1,1,1);
    // timeout into ERROR, start ignored, reset clears
    for (int i = 0; i < MT; i++) cyc(0,0,0,0,0,0,0,1,0);
    cyc(0,1,0,0,0,0,0,1,0);
    cyc(0,1,1,8,8,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    // stall counter saturation
    cyc(0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < CMAX + 6; i++) cyc(0,0,1,5,5,1,0,0,0);
    // randomized traffic
    cyc(1,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0,99) == 0, $urandom_range(0,3) == 0,
          $urandom_range(0,1) == 1, int'($urandom_range(0,3)),
          int'($urandom_range(0,3)), int'($urandom_range(0,3)),
          $urandom_range(0,2) == 0, $urandom_range(0,2) == 0,
          $urandom_range(0,3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage MIPS core.
- Detects load-use hazards and drives the bubble-select input of the ID-stage control mux.
- Gates PC and IF/ID writes, and flushes IF/ID on taken branches.
- Freezes the whole pipeline while a MEM-stage data access waits for memory acknowledge, with a watchdog timeout and hazard statistics.

Parameters:
MEM_TIMEOUT, 64, max cycles in MEMWAIT before entering ERROR (valid range 2..255)
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  leave IDLE and begin execution
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  destination register of the EX-stage load
ifid_rs_i  in  5  rs of the instruction in ID
ifid_rt_i  in  5  rt of the instruction in ID
branch_taken_i  in  1  branch resolved taken in ID
mem_req_i  in  1  MEM-stage instruction accesses data memory
mem_ack_i  in  1  data memory access complete this cycle
pc_write_o  out  1  PC register write enable
ifid_write_o  out  1  IF/ID register write enable
bubble_o  out  1  zero the control signals entering ID/EX
ifid_flush_o  out  1  clear IF/ID to a nop
freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB registers
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  load-use bubbles inserted
freeze_cnt_o  out  CNT_W  cycles spent frozen

Behaviour:
- States: IDLE, RUN, MEMWAIT, ERROR. The state register is clocked; all control outputs are combinational from the current state and inputs, taking effect in the same cycle.
- Reset: state=IDLE, wait counter=0, err_o=0, both counters=0. Reset takes priority over every other event, including mid-MEMWAIT (a pending access is abandoned).
- IDLE outputs: pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=0, freeze_o=0.
  - start_i=1 moves to RUN on the next edge.
- freeze condition: (RUN and mem_req_i and !mem_ack_i) or (MEMWAIT and !mem_ack_i).
  - While frozen: freeze_o=1, pc_write_o=0, ifid_write_o=0, bubble_o=0, ifid_flush_o=0.
  - Load-use and branch are not evaluated while frozen.
- RUN to MEMWAIT: when mem_req_i=1 and mem_ack_i=0.
- RUN with mem_req_i=1 and mem_ack_i=1: no freeze, stay in RUN (zero-wait access).
- MEMWAIT:
  - Wait counter increments every cycle.
  - mem_ack_i=1 returns to RUN on the next edge, and freeze_o=0 in the ack cycle.
  - If the counter reaches MEM_TIMEOUT-1 without ack, go to ERROR and set err_o.
  - The counter clears on every entry to MEMWAIT.
- load_use = idex_memread_i and idex_rt_i!=0 and (idex_rt_i==ifid_rs_i or idex_rt_i==ifid_rt_i).
- RUN, not frozen, load_use=1: pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=0.
  - Load-use has priority over a simultaneous branch_taken_i; the branch re-resolves the next cycle.
- RUN, not frozen, no load_use: pc_write_o=1, ifid_write_o=1, bubble_o=0, ifid_flush_o=branch_taken_i.
- ERROR: same outputs as IDLE, plus err_o=1. Only rst_i exits ERROR; start_i is ignored.
- Counters:
  - stall_cnt_o increments in each cycle where a load-use bubble is inserted.
  - freeze_cnt_o increments in each cycle where freeze_o=1.
  - Both saturate at all-ones and never wrap.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cnt_o and freeze_cnt_o behave as specified above.
- Undefined: no counter registers are built, both outputs are tied to 0, and all other behaviour is identical.

Test Plan:
- Reset held, then start_i=1 -> outputs at IDLE values while waiting; next cycle RUN with pc_write_o=1, ifid_write_o=1, bubble_o=0.
- idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> same cycle pc_write_o=0, ifid_write_o=0, bubble_o=1, stall_cnt_o=1 after the edge. Repeat with idex_rt_i=0 -> no stall.
- Load-use and branch_taken_i together -> bubble_o=1, ifid_flush_o=0. Next cycle with the load gone and branch still taken -> ifid_flush_o=1.
- mem_req_i=1 with ack after 3 wait cycles -> freeze_o=1 for exactly 3 cycles and 0 in the ack cycle, freeze_cnt_o=3. A concurrent load-use during the freeze produces no bubble.
- MEM_TIMEOUT=8, mem_req_i=1, no ack -> ERROR with err_o=1 after 8 frozen cycles; start_i ignored; rst_i clears to IDLE with err_o=0.
- Drive 2^CNT_W+5 load-use cycles (CNT_W=4 build) -> stall_cnt_o saturates at 15. Build without HAZARD_STATS_EN -> both counters read 0.
